// File: rtl/i2d_id_stage_if.sv
`default_nettype none
// ==========================================================================
// Module  : i2d_id_stage_if -- fetch-to-decode valid/ready instruction bundle
// Revision: 1.0 - initial release
// ==========================================================================
interface i2d_id_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_ins;
  logic [XLEN-1:0] if_pc;

  modport master (output if_valid, output if_ins, output if_pc, input if_ready);
  modport slave  (input if_valid, input if_ins, input if_pc, output if_ready);
endinterface
`default_nettype wire

// File: rtl/i2d_id_stage.sv
`default_nettype none
// ==========================================================================
// Module  : i2d_id_stage -- instruction decode with 1-entry skid and flush.
//           Optional macro I2D_ID_PRIV_EN: RFE in user mode (sr[0]=1) is illegal.
// Revision: 1.0 - initial release
// ==========================================================================
module i2d_id_stage #(
  parameter int XLEN    = 32,
  parameter int RIDX    = 6,
  parameter int IMM_I_W = 20,
  parameter int IMM_J_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  i2d_id_stage_if.slave    fetch,
  input  logic [XLEN-1:0]  sr,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             id_valid,
  output logic [31:0]      id_ins,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  imm,
  output logic [RIDX-1:0]  rf_ra,
  output logic [RIDX-1:0]  rf_rb,
  output logic             rf_ra_en,
  output logic             rf_rb_en,
  output logic [3:0]       alu_op,
  output logic             branch,
  output logic             swi,
  output logic             id_err
);

  localparam logic [5:0] c_op_b    = 6'h20;
  localparam logic [5:0] c_op_call = 6'h21;
  localparam logic [5:0] c_op_br   = 6'h22;
  localparam logic [5:0] c_op_swi  = 6'h30;
  localparam logic [5:0] c_op_rfe  = 6'h31;

  logic            r_skid_full;
  logic [31:0]     r_skid_ins;
  logic [XLEN-1:0] r_skid_pc;

  logic            w_accept;
  logic            w_load;
  logic            w_clear;
  logic [31:0]     w_src_ins;
  logic [XLEN-1:0] w_src_pc;
  logic [5:0]      w_op;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_z;
  logic [XLEN-1:0] w_imm;
  logic            w_ra_en;
  logic            w_rb_en;
  logic [3:0]      w_alu;
  logic            w_branch;
  logic            w_swi;
  logic            w_err;

  assign fetch.if_ready = rst & ~r_skid_full;
  assign w_accept       = fetch.if_valid & fetch.if_ready & ~flush;
  assign w_load         = ~id_valid | ex_ready;
  // Output goes to a bubble when it is free to load but has nothing to load.
  assign w_clear        = ~rst | flush | (w_load & ~r_skid_full & ~w_accept);

  assign w_src_ins = r_skid_full ? r_skid_ins : fetch.if_ins;
  assign w_src_pc  = r_skid_full ? r_skid_pc  : fetch.if_pc;
  assign w_op      = w_src_ins[31:26];

  assign w_imm_i = {{(XLEN-IMM_I_W){w_src_ins[IMM_I_W-1]}}, w_src_ins[IMM_I_W-1:0]};
  assign w_imm_j = {{(XLEN-IMM_J_W){w_src_ins[IMM_J_W-1]}}, w_src_ins[IMM_J_W-1:0]};
  assign w_imm_z = {{(XLEN-IMM_J_W){1'b0}}, w_src_ins[IMM_J_W-1:0]};

`ifdef I2D_ID_PRIV_EN
  // User-mode bit travels with its instruction through the skid entry.
  logic r_skid_user;
  logic w_src_user;
  logic w_unused_sr;
  assign w_src_user  = r_skid_full ? r_skid_user : sr[0];
  assign w_unused_sr = ^sr[XLEN-1:1];
`else
  logic w_unused_sr;
  assign w_unused_sr = ^sr;
`endif

  always_comb begin
    w_imm    = '0;
    w_ra_en  = 1'b0;
    w_rb_en  = 1'b0;
    w_alu    = 4'h0;
    w_branch = 1'b0;
    w_swi    = 1'b0;
    w_err    = 1'b0;
    if (w_op[5:4] == 2'b00) begin
      w_ra_en = 1'b1;
      w_rb_en = 1'b1;
      w_alu   = w_op[3:0];
    end else if (w_op[5:4] == 2'b01) begin
      w_ra_en = 1'b1;
      w_alu   = w_op[3:0];
      w_imm   = w_imm_i;
    end else begin
      case (w_op)
        c_op_b, c_op_call: begin
          w_branch = 1'b1;
          w_imm    = w_imm_j;
        end
        c_op_br: begin
          w_branch = 1'b1;
          w_ra_en  = 1'b1;
        end
        c_op_swi: begin
          w_swi = 1'b1;
          w_imm = w_imm_z;
        end
        c_op_rfe: begin
`ifdef I2D_ID_PRIV_EN
          if (w_src_user) w_err = 1'b1;
          else            w_branch = 1'b1;
`else
          w_branch = 1'b1;
`endif
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) r_skid_full <= 1'b0;
    else if (w_load)   r_skid_full <= 1'b0;
    else if (w_accept) r_skid_full <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_load) begin
      r_skid_ins <= fetch.if_ins;
      r_skid_pc  <= fetch.if_pc;
`ifdef I2D_ID_PRIV_EN
      r_skid_user <= sr[0];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      id_valid <= 1'b0;
      id_ins   <= '0;
      id_pc    <= '0;
      imm      <= '0;
      rf_ra    <= '0;
      rf_rb    <= '0;
      rf_ra_en <= 1'b0;
      rf_rb_en <= 1'b0;
      alu_op   <= 4'h0;
      branch   <= 1'b0;
      swi      <= 1'b0;
      id_err   <= 1'b0;
    end else if (w_load) begin
      id_valid <= 1'b1;
      id_ins   <= w_src_ins;
      id_pc    <= w_src_pc;
      imm      <= w_imm;
      rf_ra    <= w_src_ins[25 -: RIDX];
      rf_rb    <= w_src_ins[25-RIDX -: RIDX];
      rf_ra_en <= w_ra_en;
      rf_rb_en <= w_rb_en;
      alu_op   <= w_alu;
      branch   <= w_branch;
      swi      <= w_swi;
      id_err   <= w_err;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2d_id_stage.sv
`default_nettype none
// Bench for i2d_id_stage: 32-bit scoreboard checks plus a 64-bit instance in lockstep.
module tb_i2d_id_stage;
  localparam int XLEN = 32;
`ifdef I2D_ID_PRIV_EN
  localparam bit PRIV = 1'b1;
`else
  localparam bit PRIV = 1'b0;
`endif

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [5:0]      ra;
    logic [5:0]      rb;
    logic            ra_en;
    logic            rb_en;
    logic [3:0]      alu;
    logic            br;
    logic            swi;
    logic            err;
  } dec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] sr;
  logic            flush;
  logic            ex_ready;
  logic            id_valid;
  logic [31:0]     id_ins;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] imm;
  logic [5:0]      rf_ra;
  logic [5:0]      rf_rb;
  logic            rf_ra_en;
  logic            rf_rb_en;
  logic [3:0]      alu_op;
  logic            branch;
  logic            swi;
  logic            id_err;

  logic [63:0]     sr64;
  logic            id_valid64;
  logic [63:0]     imm64;
  logic            branch64;
  logic [31:0]     unused_ins64;
  logic [63:0]     unused_pc64;
  logic [5:0]      unused_ra64;
  logic [5:0]      unused_rb64;
  logic            unused_ra_en64;
  logic            unused_rb_en64;
  logic [3:0]      unused_alu64;
  logic            unused_swi64;
  logic            unused_err64;

  i2d_id_stage_if #(.XLEN(32)) f ();
  i2d_id_stage_if #(.XLEN(64)) f64 ();

  assign f64.if_valid = f.if_valid;
  assign f64.if_ins   = f.if_ins;
  assign f64.if_pc    = {32'h0, f.if_pc};
  assign sr64         = {32'h0, sr};

  always #5 clk = ~clk;

  i2d_id_stage #(.XLEN(32)) u_dut (
    .clk(clk), .rst(rst), .fetch(f), .sr(sr), .flush(flush), .ex_ready(ex_ready),
    .id_valid(id_valid), .id_ins(id_ins), .id_pc(id_pc), .imm(imm),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_ra_en(rf_ra_en), .rf_rb_en(rf_rb_en),
    .alu_op(alu_op), .branch(branch), .swi(swi), .id_err(id_err)
  );

  i2d_id_stage #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst), .fetch(f64), .sr(sr64), .flush(flush), .ex_ready(ex_ready),
    .id_valid(id_valid64), .id_ins(unused_ins64), .id_pc(unused_pc64), .imm(imm64),
    .rf_ra(unused_ra64), .rf_rb(unused_rb64), .rf_ra_en(unused_ra_en64),
    .rf_rb_en(unused_rb_en64), .alu_op(unused_alu64), .branch(branch64),
    .swi(unused_swi64), .id_err(unused_err64)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  dec_t sb[$];
  dec_t e;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [25:0] fld);
    return {op, fld};
  endfunction

  // Reference decode, written from the opcode table.
  function automatic dec_t model(input logic [31:0] i, input logic [XLEN-1:0] p, input logic user);
    dec_t d;
    logic [5:0] op;
    logic signed [XLEN-1:0] s;
    d = '0;
    d.ins = i;
    d.pc  = p;
    d.ra  = i[25:20];
    d.rb  = i[19:14];
    op    = i[31:26];
    if (op <= 6'h0F) begin
      d.ra_en = 1'b1; d.rb_en = 1'b1; d.alu = op[3:0];
    end else if (op <= 6'h1F) begin
      d.ra_en = 1'b1; d.alu = op[3:0];
      s = XLEN'($signed(i[19:0]));
      d.imm = s;
    end else begin
      case (op)
        6'h20, 6'h21: begin d.br = 1'b1; s = XLEN'($signed(i[25:0])); d.imm = s; end
        6'h22:        begin d.br = 1'b1; d.ra_en = 1'b1; end
        6'h30:        begin d.swi = 1'b1; d.imm = XLEN'(i[25:0]); end
        6'h31:        if (PRIV && user) d.err = 1'b1; else d.br = 1'b1;
        default:      d.err = 1'b1;
      endcase
    end
    return d;
  endfunction

  function automatic dec_t obs();
    return {id_ins, id_pc, imm, rf_ra, rf_rb, rf_ra_en, rf_rb_en, alu_op, branch, swi, id_err};
  endfunction

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; ex_ready = 1'b1; sr = '0;
    f.if_valid = 1'b1; f.if_ins = mk(6'h10, 26'h15FFFFF); f.if_pc = 32'h100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if ({f.if_ready, id_valid, imm} !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: if_ready=%b id_valid=%b imm=%h, want 0 0 0", c, f.if_ready, id_valid, imm);
      end
    end
  endtask

  task automatic test_addi();
    rst = 1'b1;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    f.if_valid = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (id_valid !== 1'b1 || obs() !== e) begin
      n_fail++;
      $display("FAIL addi decode: valid=%b got=%h want=%h", id_valid, obs(), e);
    end
    n_chk++;
    if ({imm, alu_op, rf_ra_en, rf_rb_en} !== {32'hFFFFFFFF, 4'h0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL addi fields: imm=%h alu=%h ra_en=%b rb_en=%b, want ffffffff 0 1 0", imm, alu_op, rf_ra_en, rf_rb_en);
    end
    n_chk++;
    if (id_valid64 !== 1'b1 || imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL addi xlen64: valid=%b imm=%h, want 1 ffffffffffffffff", id_valid64, imm64);
    end
    @(negedge clk);
    n_chk++;
    if ({id_valid, branch, swi, id_err, rf_ra_en, rf_rb_en, alu_op, imm} !== '0) begin
      n_fail++;
      $display("FAIL bubble: valid=%b br=%b swi=%b err=%b alu=%h imm=%h, want all 0", id_valid, branch, swi, id_err, alu_op, imm);
    end
  endtask

  task automatic test_branch();
    f.if_valid = 1'b1; f.if_ins = mk(6'h20, 26'h0000004); f.if_pc = 32'h200; sr = '0;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    f.if_valid = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (id_valid !== 1'b1 || obs() !== e || imm !== 32'h4 || branch !== 1'b1) begin
      n_fail++;
      $display("FAIL branch: valid=%b got=%h want=%h", id_valid, obs(), e);
    end
    n_chk++;
    if (id_valid64 !== 1'b1 || imm64 !== 64'h4 || branch64 !== 1'b1) begin
      n_fail++;
      $display("FAIL branch xlen64: valid=%b imm=%h br=%b, want 1 4 1", id_valid64, imm64, branch64);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [7];
    logic        usr [7];
    tbl[0] = mk(6'h05, 26'h0A3C123); usr[0] = 1'b0;
    tbl[1] = mk(6'h1F, 26'h01ABCDE); usr[1] = 1'b0;
    tbl[2] = mk(6'h21, 26'h2000010); usr[2] = 1'b1;
    tbl[3] = mk(6'h22, 26'h0C00000); usr[3] = 1'b0;
    tbl[4] = mk(6'h30, 26'h3FFFFFF); usr[4] = 1'b0;
    tbl[5] = mk(6'h31, 26'h0000000); usr[5] = 1'b1;
    tbl[6] = mk(6'h31, 26'h0000000); usr[6] = 1'b0;
    ex_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      f.if_valid = 1'b1; f.if_ins = tbl[k]; f.if_pc = 32'h1000 + 32'(4 * k); sr = {31'h0, usr[k]};
      sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (id_valid !== 1'b1 || f.if_ready !== 1'b1 || obs() !== e) begin
        n_fail++;
        $display("FAIL b2b[%0d]: valid=%b rdy=%b got=%h want=%h", k, id_valid, f.if_ready, obs(), e);
      end
    end
    f.if_valid = 1'b0; sr = '0;
  endtask

  task automatic test_illegal();
    ex_ready = 1'b1; f.if_valid = 1'b1; sr = '0;
    f.if_ins = mk(6'h3F, 26'h1234567); f.if_pc = 32'h0000BAD0;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || {id_valid, id_err, branch, id_pc} !== {1'b1, 1'b1, 1'b0, 32'h0000BAD0}) begin
      n_fail++;
      $display("FAIL illegal 3f: valid=%b err=%b pc=%h got=%h want=%h", id_valid, id_err, id_pc, obs(), e);
    end
    f.if_ins = mk(6'h23, 26'h0000000); f.if_pc = 32'h0000BAD4;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL illegal 23: got=%h want=%h", obs(), e);
    end
    f.if_ins = mk(6'h31, 26'h0000000); f.if_pc = 32'h0000C000; sr = 32'h1;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || {id_err, branch} !== (PRIV ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL rfe user: err=%b br=%b got=%h want=%h", id_err, branch, obs(), e);
    end
    f.if_pc = 32'h0000C004; sr = '0;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || {id_err, branch} !== 2'b01) begin
      n_fail++;
      $display("FAIL rfe super: err=%b br=%b got=%h want=%h", id_err, branch, obs(), e);
    end
    f.if_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] b3;
    b3 = mk(6'h14, 26'h0080001);
    f.if_valid = 1'b0; ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0; f.if_valid = 1'b1; f.if_ins = mk(6'h02, 26'h0123456); f.if_pc = 32'h2000; sr = '0;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    n_chk++;
    if ({id_valid, f.if_ready} !== 2'b11 || obs() !== sb[0]) begin
      n_fail++;
      $display("FAIL bp beat1 out: valid=%b rdy=%b got=%h want=%h", id_valid, f.if_ready, obs(), sb[0]);
    end
    // Beat 2 carries user mode; sr drops afterwards and must not affect it.
    f.if_ins = mk(6'h31, 26'h0000000); f.if_pc = 32'h2004; sr = 32'h1;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    n_chk++;
    if ({id_valid, f.if_ready} !== 2'b10 || obs() !== sb[0]) begin
      n_fail++;
      $display("FAIL bp skid full: valid=%b rdy=%b got=%h want=%h", id_valid, f.if_ready, obs(), sb[0]);
    end
    sr = '0; f.if_ins = b3; f.if_pc = 32'h2008;
    @(negedge clk);
    ex_ready = 1'b1;
    e = sb.pop_front();
    n_chk++;
    if ({id_valid, f.if_ready} !== 2'b10 || obs() !== e) begin
      n_fail++;
      $display("FAIL bp hold beat1: valid=%b rdy=%b got=%h want=%h", id_valid, f.if_ready, obs(), e);
    end
    @(negedge clk);
    e = sb.pop_front();
    n_chk++;
    if ({id_valid, f.if_ready} !== 2'b11 || obs() !== e) begin
      n_fail++;
      $display("FAIL bp beat2 out: valid=%b rdy=%b got=%h want=%h", id_valid, f.if_ready, obs(), e);
    end
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    f.if_valid = 1'b0;
    e = sb.pop_front();
    n_chk++;
    if (id_valid !== 1'b1 || obs() !== e) begin
      n_fail++;
      $display("FAIL bp beat3 out: valid=%b got=%h want=%h", id_valid, obs(), e);
    end
    @(negedge clk);
    n_chk++;
    if (id_valid !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp drained: valid=%b pending=%0d, want 0 0", id_valid, sb.size());
    end
  endtask

  task automatic test_flush();
    f.if_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0; sr = '0;
    @(negedge clk);
    ex_ready = 1'b0; f.if_valid = 1'b1; f.if_ins = mk(6'h03, 26'h0111111); f.if_pc = 32'h3000;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    f.if_ins = mk(6'h04, 26'h0222222); f.if_pc = 32'h3004;
    sb.push_back(model(f.if_ins, f.if_pc, sr[0]));
    @(negedge clk);
    n_chk++;
    if (f.if_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush setup: if_ready=%b, want 0", f.if_ready);
    end
    flush = 1'b1; f.if_ins = mk(6'h30, 26'h0333333); f.if_pc = 32'h3008;
    sb.delete();
    @(negedge clk);
    n_chk++;
    if ({id_valid, f.if_ready, branch, swi, id_err, rf_ra_en, rf_rb_en, alu_op, imm} !== {2'b01, 41'h0}) begin
      n_fail++;
      $display("FAIL flush skid: valid=%b rdy=%b swi=%b imm=%h, want 0 1 0 0", id_valid, f.if_ready, swi, imm);
    end
    // Flush with an empty stage and a ready fetch still drops the beat.
    ex_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; f.if_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_chk++;
      if (id_valid !== 1'b0 || swi !== 1'b0) begin
        n_fail++;
        $display("FAIL flush drop[%0d]: valid=%b swi=%b ins=%h, want 0 0", c, id_valid, swi, id_ins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/i2d_id_stage.md
Name: i2d_id_stage

Overview:
- Parametrised next-generation i2d instruction decode stage. Sits between fetch (i2d_if) and execute.
- Decodes the 6-bit opcode into register-file read indices, immediate, ALU op and control flags.
- Adds valid/ready backpressure with a 1-entry skid buffer, pipeline flush, and datapath width XLEN. Instruction width is fixed at 32.

Parameters:
- XLEN, 32, datapath/PC/immediate width; legal values 32 or 64.
- RIDX, 6, register index width; fields are packed MSB-first below the opcode.
- IMM_I_W, 20, I-type immediate width, taken from ins[IMM_I_W-1:0].
- IMM_J_W, 26, J-type immediate width, taken from ins[25:0]; must be 26 or less.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  stage can accept; = rst & ~skid_full
- if_ins  in  32  fetched instruction
- if_pc  in  XLEN  PC of if_ins
- sr  in  XLEN  status register; sr[0]=1 is user mode
- flush  in  1  discard all held instructions (branch taken or exception)
- ex_ready  in  1  execute consumes the output this cycle
- id_valid  out  1  outputs hold a decoded instruction
- id_ins  out  32  instruction
- id_pc  out  XLEN  its PC
- imm  out  XLEN  sign-extended immediate
- rf_ra  out  RIDX  read port A index = ins[25 -: RIDX]
- rf_rb  out  RIDX  read port B index = ins[25-RIDX -: RIDX]
- rf_ra_en  out  1  port A read required
- rf_rb_en  out  1  port B read required
- alu_op  out  4  ALU function
- branch  out  1  control-transfer instruction
- swi  out  1  software interrupt
- id_err  out  1  illegal instruction

Behaviour:
- Reset (rst=0 at posedge):
  - id_valid, skid_full and every decoded output clear to 0.
  - if_ready is 0 while rst=0.
- Accept rule: a beat is accepted on a posedge with if_valid & if_ready & ~flush.
- Output-register load: the output register loads when ~id_valid | ex_ready. Source is the skid entry if skid_full, else the accepted beat.
  - If neither is available, the output becomes a bubble: id_valid=0 and all control outputs 0.
- Skid buffer: if a beat is accepted while id_valid & ~ex_ready, it goes to the skid buffer (skid_full=1).
  - The skid drains to the output on the next ex_ready.
  - In that same cycle a new beat may be accepted into the output only if the skid is empty afterwards.
  - Order is strictly preserved.
- Latency: 1 cycle from accept to id_valid when the stage is empty. Full throughput of 1 instruction per cycle when ex_ready is held 1.
- Stability: while id_valid & ~ex_ready, all outputs hold.
- Flush: has priority over accept, skid drain and ex_ready.
  - Next posedge: id_valid=0, skid_full=0, controls 0.
  - The beat presented in the flush cycle is dropped.
- Decode (op = ins[31:26]); all signals not listed for a row are 0:
  - op[5:4]=00 (R-type ALU): rf_ra_en=1, rf_rb_en=1, alu_op=op[3:0].
  - op[5:4]=01 (I-type ALU, incl. MOVI = 6'h1F): rf_ra_en=1, alu_op=op[3:0], imm=sext(ins[IMM_I_W-1:0]).
  - 6'h20 B and 6'h21 CALL: branch=1, imm=sext(ins[IMM_J_W-1:0]).
  - 6'h22 BR: branch=1, rf_ra_en=1.
  - 6'h30 SWI: swi=1, imm=zext(ins[IMM_J_W-1:0]).
  - 6'h31 RFE: branch=1.
  - All other opcodes: id_err=1, every other control 0. id_ins and id_pc are still valid so the exception PC can be taken.
- sr sampling: sr is sampled at the accept edge and decoded together with its instruction.
- Width rule: sign extension replicates the field MSB up to XLEN. For XLEN=64 the result is identical in the low 32 bits.

Optional Feature:
- Macro: I2D_ID_PRIV_EN.
- Defined: RFE (6'h31) decoded while sr[0]=1 produces id_err=1, branch=0. In supervisor mode it decodes normally.
- Undefined: RFE decodes as branch=1 regardless of sr, and sr is unused.

Test Plan:
- Reset: hold rst=0 for 3 cycles with if_valid=1 -> if_ready=0, id_valid=0, imm=0. First accept occurs at the first edge with rst=1.
- ADDI (op 6'h10), ins[19:0]=20'hFFFFF, ex_ready=1 -> one cycle later id_valid=1, imm=32'hFFFFFFFF, alu_op=4'h0, rf_ra_en=1, rf_rb_en=0.
- B (6'h20), ins[25:0]=26'h0000004 -> imm=32'h00000004, branch=1. The same stimulus with XLEN=64 gives imm=64'h4.
- Backpressure: 3 back-to-back beats with ex_ready=0 -> beat 1 held in the output, beat 2 in the skid, if_ready=0. Raising ex_ready yields beats 1, 2, 3 in order with no loss or duplication.
- Flush while the skid is full and if_valid=1 -> next cycle id_valid=0, if_ready=1. The flush-cycle beat never appears at the output.
- Opcode 6'h3F -> id_err=1, id_pc=if_pc. With I2D_ID_PRIV_EN: RFE with sr[0]=1 -> id_err=1; RFE with sr[0]=0 -> branch=1.
